// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: two-stage normalise / round-to-nearest-even back end
// for the single-precision multiplier, valid/ready on both sides.
module fp_mul_norm_round #(
   parameter int DATA_WIDTH = 32,
   parameter int MENT_WIDTH = 23,
   parameter int EXPO_WIDTH = 8,
   parameter int RES_WIDTH  = 48
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sign,
   input  logic signed [EXPO_WIDTH+1:0] in_exp,
   input  logic [RES_WIDTH-1:0]         in_mant,
   input  logic                         in_zero,
   input  logic                         in_except,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_result,
   output logic                         out_overflow,
   output logic                         out_underflow,
   output logic                         out_inexact
);

   localparam int EW = EXPO_WIDTH + 2;

   localparam logic signed [EW-1:0] L_EMAX = EW'((2 ** EXPO_WIDTH) - 1);
   localparam logic signed [EW-1:0] L_EONE = EW'(1);

   localparam logic [DATA_WIDTH-1:0] L_QNAN =
      {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH - 1){1'b0}}};

   // handshake wires
   logic w_s2_adv;
   logic w_s1_adv;

   // stage 1 normalise wires
   logic                 w_hi;
   logic [MENT_WIDTH-1:0] w_n_m;
   logic                 w_n_g;
   logic                 w_n_s;
   logic signed [EW-1:0] w_n_e;

   // stage 1 registers
   logic                  r_s1_valid;
   logic                  r_s1_sign;
   logic signed [EW-1:0]  r_s1_e;
   logic [MENT_WIDTH-1:0] r_s1_m;
   logic                  r_s1_g;
   logic                  r_s1_s;
   logic                  r_s1_zero;
   logic                  r_s1_exc;

   // stage 2 round/pack wires
   logic                  w_round_up;
   logic [MENT_WIDTH:0]   w_mr;
   logic signed [EW-1:0]  w_e_rnd;
   logic                  w_lost;
   logic [DATA_WIDTH-1:0] w_res;
   logic                  w_ov;
   logic                  w_uf;
   logic                  w_inx;

   // output registers
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_result;
   logic                  r_out_ov;
   logic                  r_out_uf;
   logic                  r_out_inx;

   assign w_s2_adv = ~r_out_valid | out_ready;
   assign w_s1_adv = ~r_s1_valid | w_s2_adv;
   assign in_ready = w_s1_adv & ~rst;

   assign out_valid     = r_out_valid;
   assign out_result    = r_out_result;
   assign out_overflow  = r_out_ov;
   assign out_underflow = r_out_uf;
   assign out_inexact   = r_out_inx;

   // pick the leading one (bit 47 or 46) and split off guard/sticky
   always_comb begin
      w_hi  = in_mant[RES_WIDTH-1];
      w_n_m = in_mant[RES_WIDTH-3 -: MENT_WIDTH];
      w_n_g = in_mant[RES_WIDTH-3-MENT_WIDTH];
      w_n_s = |in_mant[RES_WIDTH-4-MENT_WIDTH:0];
      w_n_e = in_exp;
      if (w_hi) begin
         w_n_m = in_mant[RES_WIDTH-2 -: MENT_WIDTH];
         w_n_g = in_mant[RES_WIDTH-2-MENT_WIDTH];
         w_n_s = |in_mant[RES_WIDTH-3-MENT_WIDTH:0];
         w_n_e = in_exp + L_EONE;
      end
   end

   // stage 1 register: holds its beat while stage 2 is stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_e     <= '0;
         r_s1_m     <= '0;
         r_s1_g     <= 1'b0;
         r_s1_s     <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_exc   <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sign <= in_sign;
            r_s1_e    <= w_n_e;
            r_s1_m    <= w_n_m;
            r_s1_g    <= w_n_g;
            r_s1_s    <= w_n_s;
            r_s1_zero <= in_zero;
            r_s1_exc  <= in_except;
         end
      end
   end

   // round to nearest even; a mantissa carry bumps the exponent
   always_comb begin
      w_round_up = r_s1_g & (r_s1_s | r_s1_m[0]);
      w_mr       = {1'b0, r_s1_m} + {{MENT_WIDTH{1'b0}}, w_round_up};
      w_e_rnd    = r_s1_e + {{(EW - 1){1'b0}}, w_mr[MENT_WIDTH]};
      w_lost     = r_s1_g | r_s1_s;
   end

   // result selection: NaN, zero, overflow, underflow, then normal
   always_comb begin
      w_res = '0;
      w_ov  = 1'b0;
      w_uf  = 1'b0;
      w_inx = 1'b0;
      if (r_s1_exc) begin
         w_res = L_QNAN;
      end else if (r_s1_zero) begin
         w_res = {r_s1_sign, {(DATA_WIDTH - 1){1'b0}}};
      end else if (w_e_rnd >= L_EMAX) begin
         w_res = {r_s1_sign, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
         w_ov  = 1'b1;
         w_inx = 1'b1;
      end else if (w_e_rnd < L_EONE) begin
         w_res = {r_s1_sign, {(DATA_WIDTH - 1){1'b0}}};
         w_uf  = 1'b1;
         w_inx = w_lost;
      end else begin
         w_res = {r_s1_sign, w_e_rnd[EXPO_WIDTH-1:0], w_mr[MENT_WIDTH-1:0]};
         w_inx = w_lost;
      end
   end

   // output register: frozen while downstream withholds out_ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_ov     <= 1'b0;
         r_out_uf     <= 1'b0;
         r_out_inx    <= 1'b0;
      end else if (w_s2_adv) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_result <= w_res;
            r_out_ov     <= w_ov;
            r_out_uf     <= w_uf;
            r_out_inx    <= w_inx;
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb_fp_mul_norm_round: directed vectors, expected results queued at
// accept time and checked in order by an independent output monitor.
module tb_fp_mul_norm_round;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               in_sign;
   logic signed [9:0]  in_exp;
   logic [47:0]        in_mant;
   logic               in_zero;
   logic               in_except;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_result;
   logic               out_overflow;
   logic               out_underflow;
   logic               out_inexact;

   // {result, overflow, underflow, inexact}
   logic [34:0] sb[$];

   int checks = 0;
   int passes = 0;
   int n_acc  = 0;

   fp_mul_norm_round dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign       (in_sign),
      .in_exp        (in_exp),
      .in_mant       (in_mant),
      .in_zero       (in_zero),
      .in_except     (in_except),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_inexact   (out_inexact)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [34:0] act,
                      input logic [34:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h, required %h", name, act, req);
   endtask

   // drive one beat, wait (bounded) for in_ready, queue its expectation
   task automatic send(input logic s, input logic signed [9:0] e,
                       input logic [47:0] m, input logic z, input logic x,
                       input logic [31:0] res, input logic ov,
                       input logic uf, input logic inx);
      int cnt;
      @(posedge clk);
      #2;
      in_valid  = 1'b1;
      in_sign   = s;
      in_exp    = e;
      in_mant   = m;
      in_zero   = z;
      in_except = x;
      cnt = 0;
      @(negedge clk);
      while (!in_ready && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (in_ready) begin
         sb.push_back({res, ov, uf, inx});
         n_acc++;
      end else begin
         chk("accept_timeout", 35'(in_ready), 35'd1);
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   // output monitor: in-order compare plus hold-while-stalled check
   initial begin : monitor
      logic        stalled;
      logic [34:0] held;
      logic [34:0] cur;
      logic [34:0] exp_v;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         cur = {out_result, out_overflow, out_underflow, out_inexact};
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid) chk("stall_hold", cur, held);
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out", cur, 35'h0);
                  checks++;
                  $display("FAIL unexpected_beat: got %h, required none", cur);
               end else begin
                  exp_v = sb.pop_front();
                  chk("result", cur, exp_v);
               end
               stalled = 1'b0;
            end else if (out_valid) begin
               stalled = 1'b1;
               held    = cur;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin : stim
      int cnt;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      in_zero   = 1'b0;
      in_except = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("reset_state", {out_valid, in_ready, out_result, out_overflow},
          35'h0);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 35'(in_ready), 35'd1);

      // basic, rounding, carry, overflow, underflow, specials
      send(0, 127,  48'h900000000000, 0, 0, 32'h40100000, 0, 0, 0);
      send(0, 127,  48'h400000400000, 0, 0, 32'h3F800000, 0, 0, 1);
      send(0, 127,  48'h400000C00000, 0, 0, 32'h3F800002, 0, 0, 1);
      send(0, 127,  48'h7FFFFFC00000, 0, 0, 32'h40000000, 0, 0, 1);
      send(0, 254,  48'h800000000000, 0, 0, 32'h7F800000, 1, 0, 1);
      send(1, -5,   48'h400000000000, 0, 0, 32'h80000000, 0, 1, 0);
      send(0, 127,  48'h400000000000, 0, 1, 32'h7FC00000, 0, 0, 0);
      send(1, 127,  48'h400000000000, 1, 0, 32'h80000000, 0, 0, 0);
      send(0, 254,  48'h400000000000, 0, 0, 32'h7F000000, 0, 0, 0);
      send(0, 1,    48'h400000000000, 0, 0, 32'h00800000, 0, 0, 0);
      send(0, 0,    48'h400000000000, 0, 0, 32'h00000000, 0, 1, 0);
      send(0, 254,  48'h7FFFFFC00000, 0, 0, 32'h7F800000, 1, 0, 1);
      send(1, -1,   48'h800000000001, 0, 0, 32'h80000000, 0, 1, 1);
      send(1, 127,  48'h400000000000, 1, 1, 32'h7FC00000, 0, 0, 0);
      send(1, 127,  48'h900000000000, 0, 0, 32'hC0100000, 0, 0, 0);
      send(0, 127,  48'h400000600000, 0, 0, 32'h3F800001, 0, 0, 1);
      send(0, 127,  48'h400000200000, 0, 0, 32'h3F800000, 0, 0, 1);
      send(0, 381,  48'h800000000000, 0, 0, 32'h7F800000, 1, 0, 1);
      send(0, -127, 48'h400000000000, 0, 0, 32'h00000000, 0, 1, 0);
      idle();
      repeat (5) @(negedge clk);

      // backpressure: only two beats fit while out_ready is low
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      cnt = n_acc;
      fork
         begin
            send(0, 127, 48'h900000000000, 0, 0, 32'h40100000, 0, 0, 0);
            send(0, 127, 48'h400000C00000, 0, 0, 32'h3F800002, 0, 0, 1);
            send(0, 127, 48'h7FFFFFC00000, 0, 0, 32'h40000000, 0, 0, 1);
            send(1, 127, 48'h900000000000, 0, 0, 32'hC0100000, 0, 0, 0);
            idle();
         end
         begin
            repeat (6) @(negedge clk);
            chk("bp_accepted", 35'(n_acc - cnt), 35'd2);
            chk("bp_in_ready", {in_ready, out_valid}, 35'b01);
            @(posedge clk);
            #2;
            out_ready = 1'b1;
         end
      join
      repeat (6) @(negedge clk);

      // reset with two beats in flight discards them
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      send(0, 127, 48'h900000000000, 0, 0, 32'h40100000, 0, 0, 0);
      send(0, 127, 48'h400000C00000, 0, 0, 32'h3F800002, 0, 0, 1);
      idle();
      @(posedge clk);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("midrst_outputs",
          {in_ready, out_valid, out_result, out_overflow}, 35'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", {in_ready, out_valid}, 35'b10);
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      send(0, 127, 48'h400000400000, 0, 0, 32'h3F800000, 0, 0, 1);
      idle();

      cnt = 0;
      while (sb.size() != 0 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk("drain", 35'(sb.size()), 35'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fp_mul_norm_round.md
# fp_mul_norm_round

Two-stage pipelined normalise-and-round back end for the single-precision floating-point multiplier. It consumes the raw sign, biased exponent sum and 48-bit mantissa product from the multiplier core. It performs IEEE 754 round-to-nearest-even, handles overflow, underflow and exceptions, and emits a packed 32-bit result with status flags. Both ports use a valid/ready handshake, so the multiplier can be stalled by downstream consumers.

## Interface
- DATA_WIDTH, 32, packed result width
- MENT_WIDTH, 23, stored mantissa bits
- EXPO_WIDTH, 8, stored exponent bits
- RES_WIDTH, 48, mantissa product width, equal to 2*(MENT_WIDTH+1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_sign  in  1  product sign, s1^s2
- in_exp  in  EXPO_WIDTH+2  signed two's-complement exponent e1+e2-127; range -127..381
- in_mant  in  RES_WIDTH  product {1,m1}*{1,m2}; bit 47 or bit 46 is always set
- in_zero  in  1  an operand had exponent 0, so the result is signed zero
- in_except  in  1  an operand had exponent 255
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  DATA_WIDTH  {sign, exp[7:0], mant[22:0]}
- out_overflow  out  1  result saturated to infinity
- out_underflow  out  1  result flushed to zero
- out_inexact  out  1  guard or sticky bit nonzero, or overflow

## Operation
- **Stage 1, normalise:**
  - If in_mant[47]=1: m = in_mant[46:24], guard = in_mant[23], sticky = |in_mant[22:0], e = in_exp+1.
  - Else: m = in_mant[45:23], guard = in_mant[22], sticky = |in_mant[21:0], e = in_exp.
  - Registers: sign, e (10-bit signed), m, guard, sticky, zero, except.
- **Stage 2, round and pack:**
  - round_up = guard & (sticky | m[0]).
  - mr = {1'b0,m} + round_up. If mr[23] carries out, m becomes 0 and e becomes e+1.
- **Result priority, highest first:**
  - except: 0x7FC00000 (quiet NaN). All flags 0.
  - zero: {sign, 31'b0}. All flags 0.
  - e >= 255: {sign, 8'hFF, 23'b0}. overflow=1, inexact=1.
  - e <= 0: {sign, 31'b0}. underflow=1, inexact = guard|sticky. No denormal output is produced.
  - Otherwise: {sign, e[7:0], m}. inexact = guard|sticky.
- All exponent arithmetic is 10-bit signed, so no wrap is possible within the legal input range.

## Timing
- Latency is 2 cycles from the in_valid&in_ready accept edge to out_valid. Throughput is 1 beat/cycle while out_ready=1.
- Stall rules:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv & !rst. This is combinational from registers and out_ready.
- While out_valid=1 and out_ready=0: out_result and all flags hold stable, and stage 1 holds its beat.
- Under backpressure the block holds at most 2 beats. No beat is dropped or duplicated, and order is preserved.
- Simultaneous accept and emit in the same cycle is legal when full and out_ready=1; the pipeline shifts.
- Reset, asynchronous with assertion taking effect immediately:
  - s1_valid=0, out_valid=0, out_result=0, all flags 0, in_ready=0 while rst is asserted.
  - After reset, in_ready=1.
  - Reset mid-operation discards in-flight beats.

## Test plan
- **Basic product:** in_exp=127, in_mant=0x900000000000, sign 0 -> 2 cycles later out_result=0x40100000 (2.25), all flags 0.
- **Round-to-nearest-even:**
  - in_exp=127, in_mant=0x400000400000 -> 0x3F800000 with inexact=1 (tie, even, no round-up).
  - in_mant=0x400000C00000 -> 0x3F800002 (tie, odd, round-up).
- **Carry on rounding:** in_exp=127, in_mant=0x7FFFFFC00000 -> 0x40000000, inexact=1.
- **Overflow, underflow, special inputs:**
  - in_exp=254, in_mant=0x800000000000, sign 0 -> 0x7F800000 with overflow=1, inexact=1.
  - in_exp=-5, sign 1 -> 0x80000000 with underflow=1.
  - in_except=1 -> 0x7FC00000.
  - in_zero=1, sign 1 -> 0x80000000.
- **Backpressure:** push 4 beats back-to-back with out_ready=0 -> in_ready drops after 2 accepted. Release out_ready -> all 4 results emerge in order, with results stable while stalled.
- **Mid-operation reset:** assert rst with 2 beats in flight -> out_valid=0 and out_result=0 immediately. After release, in_ready=1 and no stale beat appears.
